pc_ir_unit: RTL and testbench
=============================

# pc_ir_unit

Program-counter and instruction-register stage of the multicycle MIPS core, directly downstream of the FSM controller. Consumes the controller's PCSrc/PCWrite/Branch/BranchCtrl/IRWrite/IorD strobes plus ALU result and zero flag. Holds PC, IR, MDR and ALUOut, and produces the memory address and decoded instruction fields (op, funct, ...) that feed back into the controller and datapath. Also counts fetched instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_en  in  1  state clock; all registers update on its rising edge
- rst  in  1  reset; asynchronous, active-high
- PCWrite, Branch, BranchCtrl, IRWrite, IorD  in  1 each  controller strobes
- PCSrc  in  2  next-PC select
- alu_result  in  32  combinational ALU output
- alu_zero  in  1  ALU result == 0
- mem_rdata  in  32  memory read data
- pc  out  32  program counter
- mem_addr  out  32  memory address; IorD ? alu_out : pc (combinational)
- instr  out  32  instruction register
- op, funct  out  6 each  instr[31:26], instr[5:0]
- rs, rt, rd, shamt  out  5 each  instr[25:21], [20:16], [15:11], [10:6]
- imm  out  16  instr[15:0]
- mdr  out  32  memory data register
- alu_out  out  32  registered ALU result
- instr_count  out  32  number of IR loads since reset
- pc_fault  out  1  sticky misaligned-target flag (tied 0 when feature absent)
- fault_addr  out  32  rejected PC target (tied 0 when feature absent)

## Operation
- Reset values: pc=RESET_PC; instr, mdr, alu_out, instr_count, fault_addr = 0; pc_fault=0.
- pc_next by PCSrc: 00 alu_result; 01 alu_out (branch target); 10 {pc[31:28], instr[25:0], 2'b00}; 11 pc (hold, reserved).
- pc_en = PCWrite | (Branch & (alu_zero ^ BranchCtrl)): BEQ takes when zero=1, BNE when zero=0.
- PCWrite and a taken branch together: single load of pc_next; no double effect.
- IRWrite=1: instr <= mem_rdata and instr_count <= instr_count+1. Counter wraps from 32'hFFFF_FFFF to 0.
- alu_out <= alu_result and mdr <= mem_rdata every edge, no enable.
- Field outputs are pure slices of the instr register, so they stay stable between IR loads.

## Timing
- Single-cycle update: strobes sampled at the same edge at which the controller leaves its current state.
- Fetch edge: instr takes the word at the old pc; pc takes alu_result (pc+4). The new op/funct is visible to the controller in Decode.
- Decode edge: alu_out captures the branch target. On the BEQ/BNE execute edge, PCSrc=01 loads that target if the branch is taken.
- JAL: pc loads the jump target on the JalExecute edge. alu_out holds the link value during JalWrite.
- rst asserted mid-instruction: all registers return to reset values immediately, with no wait for the clock. The first edge after release performs a normal Fetch from RESET_PC.

## Configuration
- PC_ALIGN_CHECK_EN defined: when pc_en=1 and pc_next[1:0]!=2'b00, the unit does the following.
  - pc is not updated.
  - pc_fault is set (sticky until rst) and fault_addr <= pc_next.
  - While pc_fault=1, all further pc and instr loads are suppressed; instr_count freezes.
  - If the first fault and IRWrite occur on the same edge, the IR load is still suppressed.
- Undefined: pc_next is loaded unchecked, and pc_fault and fault_addr are constant 0.

## Structure
- Shared package cpu_pkg holds the following.
  - PCSrc encodings: PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_HOLD=2'b11.
  - Instruction field bit-position constants.
  - The default RESET_PC value.
- One sub-module: pc_next_sel, a combinational mux plus the pc_en/branch-decision logic. Registers stay in pc_ir_unit.

## Test plan
- Reset with RESET_PC=32'h0000_0040 → pc=32'h40 and all other outputs 0. Then IRWrite=1, PCWrite=1, PCSrc=00, alu_result=32'h44, mem_rdata=32'h2008_0005 → pc=32'h44, instr=32'h20080005, op=6'h08, rt=5'd8, imm=16'h0005, instr_count=1.
- BEQ: alu_out preloaded 32'h100, Branch=1, BranchCtrl=0, PCSrc=01. alu_zero=1 → pc=32'h100; alu_zero=0 → pc unchanged. BNE (BranchCtrl=1) gives the opposite result.
- Jump: pc=32'h1000_0008, instr=32'h0800_0010, PCSrc=10, PCWrite=1 → pc=32'h1000_0040. IorD=1 with alu_out=32'h200 → mem_addr=32'h200.
- Counter wrap: instr_count forced near max via 2^32-1 IR loads (or a backdoor deposit) → next IRWrite gives 0. Async rst pulse between edges → immediate clear.
- PC_ALIGN_CHECK_EN: PCWrite=1, alu_result=32'h0000_0046 → pc unchanged, pc_fault=1, fault_addr=32'h46. Subsequent IRWrite/PCWrite are ignored until rst. Without the macro → pc=32'h46 and pc_fault=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: PCSrc encodings,
// instruction field bit positions and the default reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pc_src_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JIDX_MSB  = 25;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC multiplexer and PC write-enable / branch-decision logic for
// pc_ir_unit. Purely combinational.
module pc_next_sel
    import cpu_pkg::*;
(
    input  pc_src_e     pc_src_i,
    input  logic        pc_write_i,
    input  logic        branch_i,
    input  logic        branch_ctrl_i,
    input  logic        alu_zero_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] pc_i,
    input  logic [25:0] jump_idx_i,
    output logic [31:0] pc_next_o,
    output logic        pc_en_o
);

    // BranchCtrl=0 is BEQ (take on zero), BranchCtrl=1 is BNE (take on non-zero).
    logic branch_taken;
    assign branch_taken = branch_i & (alu_zero_i ^ branch_ctrl_i);
    assign pc_en_o      = pc_write_i | branch_taken;

    // NOTE: assign a default before the case so no path leaves pc_next_o
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pc_next_o = pc_i;
        case (pc_src_i)
            PCSRC_ALU:    pc_next_o = alu_result_i;
            PCSRC_ALUOUT: pc_next_o = alu_out_i;
            PCSRC_JUMP:   pc_next_o = {pc_i[31:28], jump_idx_i, 2'b00};
            PCSRC_HOLD:   pc_next_o = pc_i;
            default:      pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / MDR / ALUOut register stage of the multicycle MIPS core.
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_en,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        BranchCtrl,
    input  logic        IRWrite,
    input  logic        IorD,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [31:0] mdr,
    output logic [31:0] alu_out,
    output logic [31:0] instr_count,
    output logic        pc_fault,
    output logic [31:0] fault_addr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mdr_q;
    logic [31:0] alu_out_q;
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        pc_load;
    logic        ir_load;

    pc_next_sel u_pc_next_sel (
        .pc_src_i      (pc_src_e'(PCSrc)),
        .pc_write_i    (PCWrite),
        .branch_i      (Branch),
        .branch_ctrl_i (BranchCtrl),
        .alu_zero_i    (alu_zero),
        .alu_result_i  (alu_result),
        .alu_out_i     (alu_out_q),
        .pc_i          (pc_q),
        .jump_idx_i    (instr_q[JIDX_MSB:0]),
        .pc_next_o     (pc_next),
        .pc_en_o       (pc_en)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic        pc_fault_q, pc_fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        misaligned;
    logic        fault_set;

    assign misaligned = pc_en & (pc_next[1:0] != 2'b00);
    assign fault_set  = misaligned & ~pc_fault_q;
    // The faulting edge itself already blocks the IR load.
    assign pc_load    = pc_en & ~misaligned & ~pc_fault_q;
    assign ir_load    = IRWrite & ~misaligned & ~pc_fault_q;

    always_comb begin
        pc_fault_d   = pc_fault_q;
        fault_addr_d = fault_addr_q;
        if (fault_set) begin
            pc_fault_d   = 1'b1;
            fault_addr_d = pc_next;
        end
    end

    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            pc_fault_q   <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            pc_fault_q   <= pc_fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc_fault   = pc_fault_q;
    assign fault_addr = fault_addr_q;
`else
    assign pc_load    = pc_en;
    assign ir_load    = IRWrite;
    assign pc_fault   = 1'b0;
    assign fault_addr = 32'h0;
`endif

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        if (pc_load) begin
            pc_d = pc_next;
        end
        if (ir_load) begin
            instr_d       = mem_rdata;
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            mdr_q         <= 32'h0;
            alu_out_q     <= 32'h0;
            instr_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            mdr_q         <= mem_rdata;
            alu_out_q     <= alu_result;
            instr_count_q <= instr_count_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign mdr         = mdr_q;
    assign alu_out     = alu_out_q;
    assign instr_count = instr_count_q;
    assign mem_addr    = IorD ? alu_out_q : pc_q;

    assign op    = instr_q[OP_MSB:OP_LSB];
    assign rs    = instr_q[RS_MSB:RS_LSB];
    assign rt    = instr_q[RT_MSB:RT_LSB];
    assign rd    = instr_q[RD_MSB:RD_LSB];
    assign shamt = instr_q[SHAMT_MSB:SHAMT_LSB];
    assign funct = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign imm   = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed self-checking bench for pc_ir_unit; expectations are hand-computed.
// Follows PC_ALIGN_CHECK_EN to pick the expected misalignment behaviour.
module tb_pc_ir_unit;

    logic        clk_en = 1'b0;
    logic        rst;
    logic        PCWrite, Branch, BranchCtrl, IRWrite, IorD;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_rdata;
    logic [31:0] pc, mem_addr, instr, mdr, alu_out, instr_count, fault_addr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic        pc_fault;

    int checks = 0;
    int errors = 0;

    pc_ir_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk_en      (clk_en),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .Branch      (Branch),
        .BranchCtrl  (BranchCtrl),
        .IRWrite     (IRWrite),
        .IorD        (IorD),
        .PCSrc       (PCSrc),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .mem_rdata   (mem_rdata),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .imm         (imm),
        .mdr         (mdr),
        .alu_out     (alu_out),
        .instr_count (instr_count),
        .pc_fault    (pc_fault),
        .fault_addr  (fault_addr)
    );

    always #5 clk_en = ~clk_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the current strobes across one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk_en);
        #1;
    endtask

    task automatic idle();
        PCWrite = 0; Branch = 0; BranchCtrl = 0; IRWrite = 0; IorD = 0;
        PCSrc = 2'b00; alu_zero = 0;
    endtask

    initial begin
        idle();
        alu_result = 32'h0; mem_rdata = 32'h0;
        rst = 1'b1;
        #12;
        check("rst_pc", pc, 32'h40);
        check("rst_instr", instr, 32'h0);
        check("rst_mdr", mdr, 32'h0);
        check("rst_alu_out", alu_out, 32'h0);
        check("rst_count", instr_count, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h40);
        check("rst_fault", {31'h0, pc_fault}, 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        rst = 1'b0;

        // Fetch of addi $t0,$zero,5
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00;
        alu_result = 32'h44; mem_rdata = 32'h2008_0005;
        step();
        check("fetch_pc", pc, 32'h44);
        check("fetch_instr", instr, 32'h2008_0005);
        check("fetch_op", {26'h0, op}, 32'h08);
        check("fetch_rt", {27'h0, rt}, 32'd8);
        check("fetch_imm", {16'h0, imm}, 32'h5);
        check("fetch_count", instr_count, 32'd1);
        check("fetch_mdr", mdr, 32'h2008_0005);

        // Decode: alu_out captures the branch target
        idle(); alu_result = 32'h100; mem_rdata = 32'h0;
        step();
        check("dec_alu_out", alu_out, 32'h100);
        check("dec_pc_hold", pc, 32'h44);
        IorD = 1; #1;
        check("iord_mem_addr", mem_addr, 32'h100);
        IorD = 0;

        // BEQ taken; alu_out moves to 0x200 on the same edge
        Branch = 1; BranchCtrl = 0; PCSrc = 2'b01; alu_zero = 1; alu_result = 32'h200;
        step();
        check("beq_taken", pc, 32'h100);
        alu_zero = 0;
        step();
        check("beq_not_taken", pc, 32'h100);
        BranchCtrl = 1; alu_zero = 1;
        step();
        check("bne_not_taken", pc, 32'h100);
        alu_zero = 0;
        step();
        check("bne_taken", pc, 32'h200);
        idle(); IorD = 1; #1;
        check("iord_200", mem_addr, 32'h200);
        IorD = 0;

        // PCWrite plus a taken branch: a single load of alu_out
        alu_result = 32'h300;
        step();
        PCWrite = 1; Branch = 1; BranchCtrl = 0; alu_zero = 1; PCSrc = 2'b01;
        step();
        check("pcw_and_branch", pc, 32'h300);

        // Set up jump: pc=0x1000_0008, instr=j 0x40
        idle(); PCWrite = 1; IRWrite = 1;
        alu_result = 32'h1000_0008; mem_rdata = 32'h0800_0010;
        step();
        check("j_setup_pc", pc, 32'h1000_0008);
        check("j_setup_op", {26'h0, op}, 32'h02);
        check("j_count", instr_count, 32'd2);
        idle(); PCWrite = 1; PCSrc = 2'b10;
        step();
        check("jump_pc", pc, 32'h1000_0040);
        check("jump_funct", {26'h0, funct}, 32'h10);

        // PCSrc=11 holds even with PCWrite
        PCSrc = 2'b11;
        step();
        check("hold_pc", pc, 32'h1000_0040);

        // R-type field decode: add $t0,$t1,$t2 then sll $t0,$t0,2
        idle(); IRWrite = 1; mem_rdata = 32'h012A_4020;
        step();
        check("add_rs", {27'h0, rs}, 32'd9);
        check("add_rt", {27'h0, rt}, 32'd10);
        check("add_rd", {27'h0, rd}, 32'd8);
        check("add_funct", {26'h0, funct}, 32'h20);
        mem_rdata = 32'h0008_4080;
        step();
        check("sll_shamt", {27'h0, shamt}, 32'd2);
        check("sll_rt", {27'h0, rt}, 32'd8);
        check("sll_funct", {26'h0, funct}, 32'h0);
        check("sll_count", instr_count, 32'd4);
        IRWrite = 0;
        check("ir_stable_pre", instr, 32'h0008_4080);
        step();
        check("ir_stable", instr, 32'h0008_4080);

        // Counter wrap via backdoor deposit
        dut.instr_count_q = 32'hFFFF_FFFF;
        IRWrite = 1; mem_rdata = 32'h1111_1111;
        step();
        check("count_wrap", instr_count, 32'h0);
        step();
        check("count_after_wrap", instr_count, 32'd1);

        // Asynchronous reset between edges
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h40);
        check("arst_instr", instr, 32'h0);
        check("arst_count", instr_count, 32'h0);
        check("arst_alu_out", alu_out, 32'h0);
        #1 rst = 1'b0;

        // Fetch from RESET_PC after release
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00;
        alu_result = 32'h44; mem_rdata = 32'h1111_1111;
        step();
        check("refetch_pc", pc, 32'h44);
        check("refetch_count", instr_count, 32'd1);

        // Misaligned target with a simultaneous IR load
        alu_result = 32'h46; mem_rdata = 32'h2222_2222;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("mis_pc", pc, 32'h44);
        check("mis_fault", {31'h0, pc_fault}, 32'h1);
        check("mis_fault_addr", fault_addr, 32'h46);
        check("mis_instr", instr, 32'h1111_1111);
        check("mis_count", instr_count, 32'd1);
`else
        check("mis_pc", pc, 32'h46);
        check("mis_fault", {31'h0, pc_fault}, 32'h0);
        check("mis_fault_addr", fault_addr, 32'h0);
        check("mis_instr", instr, 32'h2222_2222);
        check("mis_count", instr_count, 32'd2);
`endif

        // Aligned loads after the misaligned one
        alu_result = 32'h80; mem_rdata = 32'h3333_3333;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("post_pc", pc, 32'h44);
        check("post_instr", instr, 32'h1111_1111);
        check("post_count", instr_count, 32'd1);
        check("post_fault_addr", fault_addr, 32'h46);
`else
        check("post_pc", pc, 32'h80);
        check("post_instr", instr, 32'h3333_3333);
        check("post_count", instr_count, 32'd3);
        check("post_fault_addr", fault_addr, 32'h0);
`endif

        // Reset clears the sticky fault
        idle();
        #2 rst = 1'b1;
        #1;
        check("clr_fault", {31'h0, pc_fault}, 32'h0);
        check("clr_fault_addr", fault_addr, 32'h0);
        check("clr_pc", pc, 32'h40);
        #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
